// File: rtl/segway_math_pipe.sv
// Segway wheel-speed pipeline: soft-started PID scaling and steering mix, deadzone
// compensation with saturation, per-wheel slew limiting and a filtered over-speed flag.
module segway_math_pipe #(
   parameter int W           = 12,
   parameter int SS_W        = 8,
   parameter int DZ_THRESH   = 60,
   parameter int DZ_OFFSET   = 960,
   parameter int DZ_GAIN_SH  = 4,
   parameter int SLEW        = 64,
   parameter int FAST_THRESH = 1792,
   parameter int FAST_CNT    = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pwr_up,
   input  logic         en_steer,
   input  logic         vld_in,
   input  logic [W-1:0] PID_cntrl,
   input  logic [W-1:0] steer_pot,
   output logic [W-1:0] lft_spd,
   output logic [W-1:0] rght_spd,
   output logic         vld_out,
   output logic         too_fast,
   output logic         ss_full
);
   localparam int PW = W + SS_W + 1;
   localparam int TW = W + 2;
   localparam int DW = W + 3;
   localparam int CW = $clog2(FAST_CNT + 1);

   localparam logic [W-1:0]         POT_LO  = W'(2 ** (W - 3));
   localparam logic [W-1:0]         POT_HI  = W'(7 * 2 ** (W - 3));
   localparam logic [W:0]           POT_MID = (W + 1)'(2 ** (W - 1) - 1);
   localparam logic signed [DW-1:0] DZ_T    = DW'(DZ_THRESH);
   localparam logic signed [DW-1:0] DZ_O    = DW'(DZ_OFFSET);
   localparam logic signed [DW-1:0] SAT_MAX = DW'(2 ** (W - 1) - 1);
   localparam logic signed [DW-1:0] SAT_MIN = DW'(-(2 ** (W - 1)));
   localparam logic signed [W:0]    SLEW_V  = (W + 1)'(SLEW);
   localparam logic signed [W:0]    FAST_V  = (W + 1)'(FAST_THRESH);
   localparam logic [CW-1:0]        CNT_MAX = CW'(FAST_CNT);

   function automatic logic signed [W-1:0] dz_sat(input logic signed [TW-1:0] t);
      logic signed [DW-1:0] te;
      logic signed [DW-1:0] r;
      te = DW'(t);
      if (te > DZ_T) r = te + DZ_O;
      else if (te < -DZ_T) r = te - DZ_O;
      else r = te <<< DZ_GAIN_SH;
      if (r > SAT_MAX) return W'(SAT_MAX);
      else if (r < SAT_MIN) return W'(SAT_MIN);
      else return W'(r);
   endfunction

   function automatic logic signed [W-1:0] slew(input logic signed [W-1:0] tgt,
                                                input logic signed [W-1:0] spd);
      logic signed [W:0] se;
      logic signed [W:0] diff;
      se   = (W + 1)'(spd);
      diff = (W + 1)'(tgt) - se;
      if (diff > SLEW_V) return W'(se + SLEW_V);
      else if (diff < -SLEW_V) return W'(se - SLEW_V);
      else return tgt;
   endfunction

   function automatic logic is_fast(input logic signed [W-1:0] v);
      logic signed [W:0] ve;
      ve = (W + 1)'(v);
      return (ve > FAST_V) || (ve < -FAST_V);
   endfunction

   logic [SS_W-1:0]      ss_tmr_q, ss_tmr_d;
   logic signed [PW-1:0] prod_s;
   logic [W-1:0]         pot_clip_s;
   logic signed [W:0]    s_s, s4_s, s8_s;
   logic signed [TW-1:0] scaled_s, st_s;
   logic signed [TW-1:0] lt1_q, rt1_q, lt1_d, rt1_d;
   logic signed [W-1:0]  lt2_q, rt2_q, lt2_d, rt2_d;
   logic signed [W-1:0]  lft_q, rght_q, lft_d, rght_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 too_fast_q;
   logic                 vld1_q, vld2_q, vld3_q;

   // Stage 1: soft-start scaling, steering clip/offset and wheel mix
   always_comb begin
      prod_s   = PW'($signed(PID_cntrl)) * PW'($signed({1'b0, ss_tmr_q}));
      scaled_s = TW'(prod_s >>> SS_W);
      if (steer_pot < POT_LO) pot_clip_s = POT_LO;
      else if (steer_pot > POT_HI) pot_clip_s = POT_HI;
      else pot_clip_s = steer_pot;
      s_s  = $signed({1'b0, pot_clip_s} - POT_MID);
      s4_s = s_s >>> 3'd4;
      s8_s = s_s >>> 2'd3;
      if (en_steer) st_s = TW'(s4_s) + TW'(s8_s);
      else st_s = '0;
      lt1_d = scaled_s + st_s;
      rt1_d = scaled_s - st_s;
      if (ss_tmr_q == {SS_W{1'b1}}) ss_tmr_d = ss_tmr_q;
      else ss_tmr_d = ss_tmr_q + SS_W'(1);
   end

   // Stages 2 and 3: deadzone/saturation, slew limit and over-speed persistence
   always_comb begin
      lt2_d  = dz_sat(lt1_q);
      rt2_d  = dz_sat(rt1_q);
      lft_d  = slew(lt2_q, lft_q);
      rght_d = slew(rt2_q, rght_q);
      if (is_fast(lft_d) || is_fast(rght_d)) begin
         if (cnt_q == CNT_MAX) cnt_d = cnt_q;
         else cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = '0;
      end
   end

   // Data registers; dropping pwr_up zeroes everything while samples keep flowing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_tmr_q <= '0; lt1_q <= '0; rt1_q <= '0; lt2_q <= '0; rt2_q <= '0;
         lft_q <= '0; rght_q <= '0; cnt_q <= '0; too_fast_q <= 1'b0;
      end else if (!pwr_up) begin
         ss_tmr_q <= '0; lt1_q <= '0; rt1_q <= '0; lt2_q <= '0; rt2_q <= '0;
         lft_q <= '0; rght_q <= '0; cnt_q <= '0; too_fast_q <= 1'b0;
      end else begin
         if (vld_in) begin
            ss_tmr_q <= ss_tmr_d;
            lt1_q    <= lt1_d;
            rt1_q    <= rt1_d;
         end
         if (vld1_q) begin
            lt2_q <= lt2_d;
            rt2_q <= rt2_d;
         end
         if (vld2_q) begin
            lft_q      <= lft_d;
            rght_q     <= rght_d;
            cnt_q      <= cnt_d;
            too_fast_q <= (cnt_d == CNT_MAX);
         end
      end
   end

   // Valid strobe pipeline, independent of pwr_up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld1_q <= 1'b0;
         vld2_q <= 1'b0;
         vld3_q <= 1'b0;
      end else begin
         vld1_q <= vld_in;
         vld2_q <= vld1_q;
         vld3_q <= vld2_q;
      end
   end

   assign lft_spd  = lft_q;
   assign rght_spd = rght_q;
   assign vld_out  = vld3_q;
   assign too_fast = too_fast_q;
   assign ss_full  = &ss_tmr_q;

endmodule

// File: tb/tb_segway_math_pipe.sv
// Bench for segway_math_pipe: per-cycle scoreboard against a behavioural model,
// a settled-target vector table, and hand sequences for ramps, over-speed and power drop.
module tb_segway_math_pipe;
   localparam int W = 12;

   logic         clk = 1'b0;
   logic         rst_n, pwr_up, en_steer, vld_in;
   logic [W-1:0] PID_cntrl, steer_pot, lft_spd, rght_spd;
   logic         vld_out, too_fast, ss_full;

   segway_math_pipe dut (
      .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .en_steer(en_steer), .vld_in(vld_in),
      .PID_cntrl(PID_cntrl), .steer_pot(steer_pot), .lft_spd(lft_spd), .rght_spd(rght_spd),
      .vld_out(vld_out), .too_fast(too_fast), .ss_full(ss_full)
   );

   always #5 clk = ~clk;

   typedef struct { int lt; int rt; } tgt_t;
   typedef struct { int pid; int pot; bit en; int el; int er; } vec_t;

   tgt_t sb_q[$];
   int   hist_l[$];
   int   hist_t[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   m_ss = 0, m_l = 0, m_r = 0, m_cnt = 0, m_tf = 0;
   bit   m_v1 = 1'b0, m_v2 = 1'b0, m_vo = 1'b0;

   function automatic int clamp(int v, int lo, int hi);
      if (v < lo) return lo;
      else if (v > hi) return hi;
      else return v;
   endfunction

   function automatic int dz(int t);
      int r;
      if (t > 60) r = t + 960;
      else if (t < -60) r = t - 960;
      else r = t * 16;
      return clamp(r, -2048, 2047);
   endfunction

   function automatic tgt_t model_tgt(int pid, int pot, bit en, int ss);
      tgt_t r;
      int scaled, s, st;
      scaled = (pid * ss) >>> 8;
      s      = clamp(pot, 512, 3584) - 2047;
      st     = en ? ((s >>> 4) + (s >>> 3)) : 0;
      r.lt   = dz(scaled + st);
      r.rt   = dz(scaled - st);
      return r;
   endfunction

   function automatic int slew(int tgt, int spd);
      if (tgt - spd > 64) return spd + 64;
      else if (tgt - spd < -64) return spd - 64;
      else return tgt;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic chk_hist(input string name, input int idx, input int exp, input bit tf);
      int act;
      if (tf) act = (idx < hist_t.size()) ? hist_t[idx] : -99999;
      else act = (idx < hist_l.size()) ? hist_l[idx] : -99999;
      check(name, act, exp);
   endtask

   task automatic step(input bit pwr, input bit en, input bit vld, input int pid, input int pot);
      tgt_t t;
      @(negedge clk);
      pwr_up = pwr; en_steer = en; vld_in = vld;
      PID_cntrl = pid[W-1:0]; steer_pot = pot[W-1:0];
      m_vo = m_v2; m_v2 = m_v1; m_v1 = vld;
      if (!pwr) begin
         foreach (sb_q[i]) begin sb_q[i].lt = 0; sb_q[i].rt = 0; end
         t.lt = 0; t.rt = 0;
         if (vld) sb_q.push_back(t);
         if (m_vo && sb_q.size() > 0) t = sb_q.pop_front();
         m_ss = 0; m_l = 0; m_r = 0; m_cnt = 0; m_tf = 0;
      end else begin
         if (vld) begin
            sb_q.push_back(model_tgt(pid, pot, en, m_ss));
            if (m_ss < 255) m_ss++;
         end
         if (m_vo) begin
            if (sb_q.size() == 0) begin
               check("scoreboard_empty", 0, 1);
            end else begin
               t = sb_q.pop_front();
               m_l = slew(t.lt, m_l);
               m_r = slew(t.rt, m_r);
               if (m_l > 1792 || m_l < -1792 || m_r > 1792 || m_r < -1792)
                  m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
               else
                  m_cnt = 0;
               m_tf = (m_cnt == 4) ? 1 : 0;
            end
         end
      end
      @(posedge clk);
      #1;
      check("vld_out", int'(vld_out), int'(m_vo));
      check("lft_spd", int'($signed(lft_spd)), m_l);
      check("rght_spd", int'($signed(rght_spd)), m_r);
      check("too_fast", int'(too_fast), m_tf);
      check("ss_full", int'(ss_full), (m_ss == 255) ? 1 : 0);
      if (m_vo) begin
         hist_l.push_back(int'($signed(lft_spd)));
         hist_t.push_back(int'(too_fast));
      end
   endtask

   task automatic run(input int n, input int pid, input int pot, input bit en);
      for (int i = 0; i < n; i++) step(1'b1, en, 1'b1, pid, pot);
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 2047);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[11];
      tbl[0]  = '{256, 2047, 1'b0, 1215, 1215};
      tbl[1]  = '{16, 2047, 1'b0, 240, 240};
      tbl[2]  = '{0, 4095, 1'b1, 1248, -1248};
      tbl[3]  = '{0, 4095, 1'b0, 0, 0};
      tbl[4]  = '{0, 0, 1'b1, -1248, 1248};
      tbl[5]  = '{61, 2048, 1'b0, 960, 960};
      tbl[6]  = '{62, 2048, 1'b0, 1021, 1021};
      tbl[7]  = '{-64, 2048, 1'b0, -1024, -1024};
      tbl[8]  = '{2047, 2048, 1'b0, 2047, 2047};
      tbl[9]  = '{-2047, 2048, 1'b0, -2048, -2048};
      tbl[10] = '{256, 4095, 1'b1, 1503, -528};

      rst_n = 1'b0; pwr_up = 1'b0; en_steer = 1'b0; vld_in = 1'b0;
      PID_cntrl = '0; steer_pot = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_lft", int'(lft_spd), 0);
      check("rst_rght", int'(rght_spd), 0);
      check("rst_vld_out", int'(vld_out), 0);
      check("rst_too_fast", int'(too_fast), 0);
      check("rst_ss_full", int'(ss_full), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // soft start fills after 255 accepts while speeds stay zero
      run(255, 0, 2047, 1'b0);
      check("ss_full_255", int'(ss_full), 1);

      // ramp to 1215 from rest
      drain(); hist_l.delete(); hist_t.delete();
      run(22, 256, 2047, 1'b0); drain();
      chk_hist("ramp_1st", 0, 64, 1'b0);
      chk_hist("ramp_18th", 17, 1152, 1'b0);
      chk_hist("ramp_19th", 18, 1215, 1'b0);

      for (int i = 0; i < 11; i++) begin
         run(72, tbl[i].pid, tbl[i].pot, tbl[i].en);
         check($sformatf("tbl%0d_lft", i), int'($signed(lft_spd)), tbl[i].el);
         check($sformatf("tbl%0d_rght", i), int'($signed(rght_spd)), tbl[i].er);
      end

      // forward over-speed rise and clear
      run(72, 0, 2047, 1'b0); drain(); hist_l.delete(); hist_t.delete();
      run(40, 2047, 2047, 1'b0); drain();
      chk_hist("fwd_28th", 27, 1792, 1'b0);
      chk_hist("fwd_29th", 28, 1856, 1'b0);
      chk_hist("fwd_tf_31st", 30, 0, 1'b1);
      chk_hist("fwd_tf_32nd", 31, 1, 1'b1);
      chk_hist("fwd_32nd", 31, 2047, 1'b0);
      hist_l.delete(); hist_t.delete();
      run(10, 0, 2047, 1'b0); drain();
      chk_hist("dec_tf_3rd", 2, 1, 1'b1);
      chk_hist("dec_4th", 3, 1791, 1'b0);
      chk_hist("dec_tf_4th", 3, 0, 1'b1);

      // reverse over-speed
      run(72, 0, 2047, 1'b0); drain(); hist_l.delete(); hist_t.delete();
      run(40, -2047, 2047, 1'b0); drain();
      chk_hist("rev_29th", 28, -1856, 1'b0);
      chk_hist("rev_tf_31st", 30, 0, 1'b1);
      chk_hist("rev_tf_32nd", 31, 1, 1'b1);
      chk_hist("rev_32nd", 31, -2048, 1'b0);

      // one-cycle power drop mid-ramp, with a sample accepted on the same edge
      run(72, 0, 2047, 1'b0); drain();
      run(10, 256, 2047, 1'b0);
      step(1'b0, 1'b0, 1'b1, 256, 2047);
      check("pwr_lft", int'(lft_spd), 0);
      check("pwr_too_fast", int'(too_fast), 0);
      check("pwr_ss_full", int'(ss_full), 0);
      drain(); hist_l.delete(); hist_t.delete();
      run(30, 256, 2047, 1'b0); drain();
      chk_hist("restart_1st", 0, 0, 1'b0);
      chk_hist("restart_2nd", 1, 16, 1'b0);
      chk_hist("restart_30th", 29, 464, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
